// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_pkg
// Description : Shared types and encodings for the multicycle RV32I control
//               unit. Contains the FSM state enum, the opcodes it decodes, the
//               datapath select encodings and the trap cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXEC_R   = 4'd6,
        ST_EXEC_I   = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BEQ      = 4'd9,
        ST_JAL      = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // Opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_beq    = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // ALU operation requested from the ALU decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU control
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    // Result mux
    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_readdata  = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    // ALU operand muxes
    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;
    localparam logic [1:0] c_srcb_rs2   = 2'b00;
    localparam logic [1:0] c_srcb_imm   = 2'b01;
    localparam logic [1:0] c_srcb_four  = 2'b10;

    // Immediate formats
    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    // Trap causes
    localparam logic [1:0] c_trap_none    = 2'b00;
    localparam logic [1:0] c_trap_illegal = 2'b01;
    localparam logic [1:0] c_trap_timeout = 2'b10;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational ALU control decode.
//   alu_op      in  2  add / sub / decode from funct fields
//   funct3      in  3  instruction funct3
//   funct7b5    in  1  instruction bit 30
//   opb5        in  1  opcode bit 5 (1 = R-type, 0 = I-type ALU)
//   alu_control out 3  ALU operation
//   illegal     out 1  funct3 has no supported ALU operation
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mcu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       opb5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = c_alu_add;
        // Evaluated independently of alu_op so the controller can reject an
        // unsupported funct3 while still in DECODE.
        illegal     = !(funct3 inside {3'b000, 3'b010, 3'b110, 3'b111});
        case (alu_op)
            c_aluop_sub: alu_control = c_alu_sub;
            c_aluop_funct: begin
                case (funct3)
                    3'b000:  alu_control = (opb5 && funct7b5) ? c_alu_sub : c_alu_add;
                    3'b010:  alu_control = c_alu_slt;
                    3'b110:  alu_control = c_alu_or;
                    3'b111:  alu_control = c_alu_and;
                    default: alu_control = c_alu_add;
                endcase
            end
            default: alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Moore FSM sequencing a multicycle RV32I datapath with a shared
//               instruction/data memory port (lw, sw, R-type, I-ALU, beq, jal).
//   clk, reset               clock, asynchronous active-high reset
//   instr, zero, mem_ready   IR contents, ALU zero flag, memory completion
//   mem_req, adr_src, mem_write, ir_write, pc_write, reg_write   strobes
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control      selects
//   halted, trap_cause       trap status
//   cycle_cnt, instret_cnt   performance counters (MCU_PERF_CNT_EN only)
// Optional feature macro: MCU_PERF_CNT_EN
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mcu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef MCU_PERF_CNT_EN
    , parameter int PERF_W    = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        halted,
    output logic [1:0]  trap_cause
`ifdef MCU_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);

    localparam int c_cnt_w = $clog2(MEM_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [1:0]         r_trap_cause;
    logic [1:0]         w_trap_code;
    logic               w_waiting;
    logic               w_timeout;
    logic               w_pc_update;
    logic               w_branch;
    logic [1:0]         w_alu_op;
    logic               w_funct_illegal;
    logic [6:0]         w_opcode;
    logic               w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (instr[14:12]),
        .funct7b5    (instr[30]),
        .opb5        (instr[5]),
        .alu_control (alu_control),
        .illegal     (w_funct_illegal)
    );

    // States that hold a memory request open until mem_ready.
    assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEMREAD) ||
                       (r_state == ST_MEMWRITE);
    assign w_timeout = w_waiting && !mem_ready && (r_wait_cnt == c_cnt_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_wait_cnt   <= '0;
            r_trap_cause <= c_trap_none;
        end else begin
            r_state      <= w_next;
            r_trap_cause <= w_trap_code;
            if (w_waiting && !mem_ready && (w_next == r_state)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_trap_code = r_trap_cause;
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        result_src  = c_res_aluout;
        alu_src_a   = c_srca_pc;
        alu_src_b   = c_srcb_rs2;
        imm_src     = c_imm_i;
        w_alu_op    = c_aluop_add;
        halted      = 1'b0;
        // Outputs are forced inactive for as long as reset is high so an
        // in-flight access is abandoned immediately.
        if (!reset) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = c_srca_pc;
                    alu_src_b  = c_srcb_four;
                    result_src = c_res_aluresult;
                    if (mem_ready) begin
                        ir_write    = 1'b1;
                        w_pc_update = 1'b1;
                        w_next      = ST_DECODE;
                    end else if (w_timeout) begin
                        w_next      = ST_TRAP;
                        w_trap_code = c_trap_timeout;
                    end
                end
                ST_DECODE: begin
                    // Branch target precomputed into ALUOut.
                    alu_src_a = c_srca_oldpc;
                    alu_src_b = c_srcb_imm;
                    imm_src   = c_imm_b;
                    case (w_opcode)
                        c_op_load, c_op_store: w_next = ST_MEMADR;
                        c_op_rtype: w_next = w_funct_illegal ? ST_TRAP : ST_EXEC_R;
                        c_op_itype: w_next = w_funct_illegal ? ST_TRAP : ST_EXEC_I;
                        c_op_beq:   w_next = ST_BEQ;
                        c_op_jal:   w_next = ST_JAL;
                        default:    w_next = ST_TRAP;
                    endcase
                    if (w_next == ST_TRAP) begin
                        w_trap_code = c_trap_illegal;
                    end
                end
                ST_MEMADR: begin
                    alu_src_a = c_srca_rs1;
                    alu_src_b = c_srcb_imm;
                    // Opcode bit 5 separates store from load.
                    imm_src   = instr[5] ? c_imm_s : c_imm_i;
                    w_next    = instr[5] ? ST_MEMWRITE : ST_MEMREAD;
                end
                ST_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) begin
                        w_next = ST_MEMWB;
                    end else if (w_timeout) begin
                        w_next      = ST_TRAP;
                        w_trap_code = c_trap_timeout;
                    end
                end
                ST_MEMWB: begin
                    result_src = c_res_readdata;
                    reg_write  = 1'b1;
                    w_next     = ST_FETCH;
                end
                ST_MEMWRITE: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        w_next = ST_FETCH;
                    end else if (w_timeout) begin
                        w_next      = ST_TRAP;
                        w_trap_code = c_trap_timeout;
                    end
                end
                ST_EXEC_R: begin
                    alu_src_a = c_srca_rs1;
                    alu_src_b = c_srcb_rs2;
                    w_alu_op  = c_aluop_funct;
                    w_next    = ST_ALUWB;
                end
                ST_EXEC_I: begin
                    alu_src_a = c_srca_rs1;
                    alu_src_b = c_srcb_imm;
                    imm_src   = c_imm_i;
                    w_alu_op  = c_aluop_funct;
                    w_next    = ST_ALUWB;
                end
                ST_ALUWB: begin
                    result_src = c_res_aluout;
                    reg_write  = 1'b1;
                    w_next     = ST_FETCH;
                end
                ST_BEQ: begin
                    alu_src_a  = c_srca_rs1;
                    alu_src_b  = c_srcb_rs2;
                    w_alu_op   = c_aluop_sub;
                    result_src = c_res_aluout;
                    w_branch   = 1'b1;
                    w_next     = ST_FETCH;
                end
                ST_JAL: begin
                    alu_src_a   = c_srca_oldpc;
                    alu_src_b   = c_srcb_four;
                    result_src  = c_res_aluout;
                    imm_src     = c_imm_j;
                    w_pc_update = 1'b1;
                    w_next      = ST_ALUWB;
                end
                ST_TRAP: begin
                    halted = 1'b1;
                end
                default: begin
                    w_next = ST_FETCH;
                end
            endcase
        end
    end

    assign pc_write   = w_pc_update | (w_branch & zero);
    assign trap_cause = r_trap_cause;

`ifdef MCU_PERF_CNT_EN
    logic [PERF_W-1:0] r_cycle_cnt;
    logic [PERF_W-1:0] r_instret_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != ST_TRAP) begin
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            end
            // Any return to FETCH marks a retired instruction.
            if ((r_state != ST_FETCH) && (w_next == ST_FETCH)) begin
                r_instret_cnt <= r_instret_cnt + 1'b1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    // Performance counters not built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Random and
//               directed instruction streams; expected per-cycle control
//               words come from the instruction-class step tables below.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        halted;
    logic [1:0]  trap_cause;
`ifdef MCU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .halted      (halted),
        .trap_cause  (trap_cause)
`ifdef MCU_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    // {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, imm_src, alu_control, halted, trap_cause}
    logic [19:0] w_obs;
    assign w_obs = {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
                    result_src, alu_src_a, alu_src_b, imm_src, alu_control,
                    halted, trap_cause};

    function automatic logic [19:0] ev(input int req, input int adr, input int mw,
                                       input int irw, input int pcw, input int rw,
                                       input int rs, input int sa, input int sb,
                                       input int imm, input int alu, input int h,
                                       input int cause);
        return {1'(req), 1'(adr), 1'(mw), 1'(irw), 1'(pcw), 1'(rw), 2'(rs),
                2'(sa), 2'(sb), 2'(imm), 3'(alu), 1'(h), 2'(cause)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs are set at the falling edge; outputs sampled 1 time unit later.
    task automatic step(input string tag, input logic [19:0] e);
        #1;
        check(tag, 64'(w_obs), 64'(e));
        @(negedge clk);
    endtask

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[6:0] == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_legal(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (op == 7'h33 || op == 7'h13)
            return ins[14:12] inside {3'b000, 3'b010, 3'b110, 3'b111};
        return op inside {7'h03, 7'h23, 7'h63, 7'h6F};
    endfunction

    task automatic noise();
        mem_ready = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b1;
        step("reset_outputs", 20'd0);
        step("reset_held", 20'd0);
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] ins, input int st_f, input int st_m,
                             output bit trapped);
        logic [6:0] op;
        bit         isw;
        trapped = 1'b0;
        op      = ins[6:0];
        for (int k = 0; k < st_f; k++) begin
            mem_ready = 1'b0;
            zero      = 1'($urandom_range(0, 1));
            step("fetch_wait", ev(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        end
        mem_ready = 1'b1;
        step("fetch", ev(1, 0, 0, 1, 1, 0, 2, 0, 2, 0, 0, 0, 0));
        instr = ins;
        noise();
        step("decode", ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0, 0));
        noise();
        if (!is_legal(ins)) begin
            step("trap_illegal", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
            trapped = 1'b1;
            return;
        end
        case (op)
            7'h03, 7'h23: begin
                isw = (op == 7'h23);
                step("memadr", ev(0, 0, 0, 0, 0, 0, 0, 2, 1, isw ? 1 : 0, 0, 0, 0));
                for (int k = 0; k < st_m; k++) begin
                    mem_ready = 1'b0;
                    step("mem_wait", ev(1, 1, isw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                end
                mem_ready = 1'b1;
                step(isw ? "memwrite" : "memread", ev(1, 1, isw, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                if (!isw) begin
                    noise();
                    step("memwb", ev(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
                end
            end
            7'h33: begin
                step("exec_r", ev(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, alu_of(ins), 0, 0));
                noise();
                step("aluwb", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            7'h13: begin
                step("exec_i", ev(0, 0, 0, 0, 0, 0, 0, 2, 1, 0, alu_of(ins), 0, 0));
                noise();
                step("aluwb", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
            7'h63: begin
                step("beq", ev(0, 0, 0, 0, zero, 0, 0, 2, 0, 0, 1, 0, 0));
            end
            default: begin
                step("jal", ev(0, 0, 0, 0, 1, 0, 0, 1, 2, 3, 0, 0, 0));
                noise();
                step("aluwb", ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0]  f3;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 9);
        f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
              : ((r[1:0] == 2'd0) ? 3'b000 : (r[1:0] == 2'd1) ? 3'b010
              : (r[1:0] == 2'd2) ? 3'b110 : 3'b111);
        case (sel)
            0, 1:    return {1'b0, r[30], 5'b0, r[24:15], f3, r[11:7], 7'h33};
            2, 3:    return {r[31:15], f3, r[11:7], 7'h13};
            4:       return {r[31:15], 3'b010, r[11:7], 7'h03};
            5:       return {r[31:15], 3'b010, r[11:7], 7'h23};
            6, 7:    return {r[31:15], 3'b000, r[11:7], 7'h63};
            8:       return {r[31:7], 7'h6F};
            default: begin
                while (r[6:0] inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F})
                    r[6:0] = 7'($urandom);
                return r;
            end
        endcase
    endfunction

    initial begin
        bit          tr;
        logic [31:0] ins;
        int          sf, sm;
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        instr     = 32'd0;
        @(negedge clk);
        do_reset();

        // Directed cases
        run_instr(32'h002081B3, 0, 0, tr);               // add
`ifdef MCU_PERF_CNT_EN
        run_instr(32'h002081B3, 0, 0, tr);
        run_instr(32'h002081B3, 0, 0, tr);
        #1;
        check("instret_cnt", 64'(instret_cnt), 64'd3);
        check("cycle_cnt", 64'(cycle_cnt), 64'd12);
`endif
        run_instr(32'h402081B3, 0, 0, tr);               // sub
        run_instr(32'h0000A183, 0, 0, tr);               // lw
        zero = 1'b1;
        #1;
        run_instr(32'h00000463, 0, 0, tr);               // beq, zero set by noise
        run_instr(32'h0000A183, 0, 3, tr);               // lw with 3-cycle stall
        run_instr(32'h0000007F, 0, 0, tr);               // illegal opcode
        check("illegal_trapped", 64'(tr), 64'd1);
        step("trap_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        do_reset();

        // Fetch that never completes
        for (int k = 0; k < 16; k++) begin
            mem_ready = 1'b0;
            step("timeout_wait", ev(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        end
        step("timeout_trap", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        mem_ready = 1'b1;
        step("timeout_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        do_reset();

        // Stall one short of the limit, then complete; then abort mid-access.
        run_instr(32'h00A12223, 15, 15, tr);             // sw
        mem_ready = 1'b0;
        step("abort_wait", ev(1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
        do_reset();

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            ins = rand_instr();
            sf  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            sm  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            run_instr(ins, sf, sm, tr);
            if (tr) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
